// File: rtl/truth_sweep_pkg.sv
// Shared definitions for the truth-table sweep controller.
// Holds the FSM state type and encodings plus the table, index, error-count
// and settle-counter widths used by truth_sweep_ctrl and sweep_settle_cnt.
package truth_sweep_pkg;

   localparam int TT_W  = 16;  // minterms in a 4-input truth table
   localparam int IDX_W = 4;   // minterm index width
   localparam int ERR_W = 5;   // holds 0..16 without overflow
   localparam int CNT_W = 4;   // settle counter, SETTLE legal range 1..15

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_DRIVE   = 2'd1;
   localparam state_t ST_CAPTURE = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/truth_sweep_ctrl_settle_cnt.sv
// sweep_settle_cnt: settle-time counter for the truth-table sweep.
// Counts enabled cycles from zero; expired flags the terminal count SETTLE-1.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   clear   - synchronous clear to zero (wins over enable)
//   enable  - advance the count by one
//   expired - high while the count equals SETTLE-1
module sweep_settle_cnt
   import truth_sweep_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == TERM);

endmodule

// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: steps a 4-input function through all 16 minterms,
// holds each for SETTLE cycles, captures the response into a truth table
// and optionally compares it against an expected table.
// Build option: define SWEEP_COMPARE_EN to include the comparison logic;
// without it expected is ignored and err_cnt/pass are tied to 0.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - sweep request, accepted only in IDLE
//   expected  - expected truth table, bit i for minterm i
//   f_in      - response of the function under test
//   abcd      - applied minterm (abcd[3]=A .. abcd[0]=D)
//   busy      - sweep in progress (DRIVE/CAPTURE)
//   done      - one-cycle completion pulse
//   table_q   - captured truth table
//   err_cnt   - number of mismatching minterms
//   pass      - err_cnt==0, valid from done until the next accepted start
//
// state   | meaning
// IDLE    | waiting for start; results and abcd hold
// DRIVE   | abcd applied, settle counter running
// CAPTURE | sample f_in for the current minterm, advance or finish
// DONE    | one-cycle done pulse, then back to IDLE
module truth_sweep_ctrl
   import truth_sweep_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [TT_W-1:0]  expected,
   input  logic             f_in,
   output logic [IDX_W-1:0] abcd,
   output logic             busy,
   output logic             done,
   output logic [TT_W-1:0]  table_q,
   output logic [ERR_W-1:0] err_cnt,
   output logic             pass
);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic             start_acc;
   logic             in_capture;
   logic             last_idx;
   logic             settle_clr;
   logic             settle_exp;

   assign start_acc  = (state == ST_IDLE) && start;
   assign in_capture = (state == ST_CAPTURE);
   assign last_idx   = (idx == IDX_W'(TT_W - 1));
   assign settle_clr = start_acc || in_capture;

   sweep_settle_cnt #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (settle_clr),
      .enable  (state == ST_DRIVE),
      .expired (settle_exp)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_DRIVE;
         ST_DRIVE:   if (settle_exp) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = last_idx ? ST_DONE : ST_DRIVE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // idx stops at 15 after the last capture so abcd reads 4'hF in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         idx     <= '0;
         table_q <= '0;
      end else begin
         state <= state_nxt;
         if (start_acc) begin
            idx     <= '0;
            table_q <= '0;
         end else if (in_capture) begin
            table_q[idx] <= f_in;
            if (!last_idx) idx <= idx + 1'b1;
         end
      end
   end

   assign abcd = idx;
   assign busy = (state == ST_DRIVE) || (state == ST_CAPTURE);
   assign done = (state == ST_DONE);

`ifdef SWEEP_COMPARE_EN
   logic [ERR_W-1:0] err_q;
   logic [ERR_W-1:0] err_nxt;
   logic             pass_q;
   logic             mismatch;

   assign mismatch = (f_in != expected[idx]);
   assign err_nxt  = err_q + ERR_W'(mismatch);

   // pass is resolved on the final capture so it is already valid with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q  <= '0;
         pass_q <= 1'b0;
      end else if (start_acc) begin
         err_q  <= '0;
         pass_q <= 1'b0;
      end else if (in_capture) begin
         err_q <= err_nxt;
         if (last_idx) pass_q <= (err_nxt == '0);
      end
   end

   assign err_cnt = err_q;
   assign pass    = pass_q;
`else
   logic unused_expected;

   assign unused_expected = ^expected;
   assign err_cnt         = '0;
   assign pass            = 1'b0;
`endif

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
module tb_truth_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0;
   logic        start3 = 1'b0;
   logic [15:0] expected = 16'h0000;
   logic [1:0]  f_sel = 2'd0;
   logic [15:0] rnd_tt = 16'h0000;

   logic        f_in1, f_in3;
   logic [3:0]  abcd1, abcd3;
   logic        busy1, busy3, done1, done3, pass1, pass3;
   logic [15:0] table1, table3;
   logic [4:0]  err1, err3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Product of maxterms M(2,3,4,7,A,B,D,F).
   function automatic logic pos_f(input logic [3:0] v);
      logic a, b, c, d;
      {a, b, c, d} = v;
      return ( a |  b | ~c |  d) & ( a |  b | ~c | ~d) &
             ( a | ~b |  c |  d) & ( a | ~b | ~c | ~d) &
             (~a |  b | ~c |  d) & (~a |  b | ~c | ~d) &
             (~a | ~b |  c | ~d) & (~a | ~b | ~c | ~d);
   endfunction

   function automatic logic src_f(input logic [3:0] v, input logic [1:0] sel,
                                  input logic [15:0] tt);
      case (sel)
         2'd0:    return pos_f(v);
         2'd1:    return 1'b0;
         default: return tt[v];
      endcase
   endfunction

   assign f_in1 = src_f(abcd1, f_sel, rnd_tt);
   assign f_in3 = src_f(abcd3, f_sel, rnd_tt);

   truth_sweep_ctrl #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected), .f_in(f_in1),
      .abcd(abcd1), .busy(busy1), .done(done1), .table_q(table1),
      .err_cnt(err1), .pass(pass1)
   );

   truth_sweep_ctrl #(.SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .expected(expected), .f_in(f_in3),
      .abcd(abcd3), .busy(busy3), .done(done3), .table_q(table3),
      .err_cnt(err3), .pass(pass3)
   );

   // Reference: the captured table is the function evaluated at every minterm,
   // the error count is the number of minterms disagreeing with expected.
   function automatic void model(input logic [1:0] sel, input logic [15:0] rtt,
                                 input logic [15:0] ex, output logic [15:0] tt,
                                 output logic [4:0] ec, output logic ps);
      int maxterms[8] = '{2, 3, 4, 7, 10, 11, 13, 15};
      int errs = 0;
      for (int i = 0; i < 16; i++) begin
         logic f;
         if (sel == 2'd0) begin
            f = 1'b1;
            foreach (maxterms[j]) if (maxterms[j] == i) f = 1'b0;
         end else if (sel == 2'd1) begin
            f = 1'b0;
         end else begin
            f = rtt[i];
         end
         tt[i] = f;
         if (f != ex[i]) errs++;
      end
`ifdef SWEEP_COMPARE_EN
      ec = 5'(errs);
      ps = (errs == 0);
`else
      ec = 5'd0;
      ps = 1'b0;
`endif
   endfunction

   // Drives one start and returns edges counted from the accepting edge
   // (inclusive) up to the edge after which done is seen.
   task automatic do_sweep(input bit use3, output int lat);
      @(posedge clk); #1;
      if (use3) start3 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      start3 = 1'b0;
      lat = 1;
      while (!(use3 ? done3 : done1) && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({abcd1, busy1, done1, table1, err1, pass1} !== 28'd0) begin
         n_bad++;
         $display("FAIL reset_dut1: got %h want 0", {abcd1, busy1, done1, table1, err1, pass1});
      end
      n_cmp++;
      if ({abcd3, busy3, done3, table3, err3, pass3} !== 28'd0) begin
         n_bad++;
         $display("FAIL reset_dut3: got %h want 0", {abcd3, busy3, done3, table3, err3, pass3});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_match;
      int lat;
      logic [15:0] tt; logic [4:0] ec; logic ps;
      f_sel = 2'd0; expected = 16'h5363;
      model(f_sel, rnd_tt, expected, tt, ec, ps);
      do_sweep(1'b0, lat);
      n_cmp++;
      if (lat !== 33) begin n_bad++; $display("FAIL match_latency: got %0d want 33", lat); end
      n_cmp++;
      if (table1 !== tt) begin n_bad++; $display("FAIL match_table: got %h want %h", table1, tt); end
      n_cmp++;
      if (err1 !== ec) begin n_bad++; $display("FAIL match_err: got %0d want %0d", err1, ec); end
      n_cmp++;
      if (pass1 !== ps) begin n_bad++; $display("FAIL match_pass: got %b want %b", pass1, ps); end
      @(posedge clk); #1;
      n_cmp++;
      if ({done1, busy1} !== 2'b00) begin
         n_bad++; $display("FAIL match_done_width: got done,busy=%b want 00", {done1, busy1});
      end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if ({abcd1, table1, err1, pass1} !== {4'hF, tt, ec, ps}) begin
         n_bad++;
         $display("FAIL match_hold: got %h want %h", {abcd1, table1, err1, pass1}, {4'hF, tt, ec, ps});
      end
   endtask

   task automatic test_one_error;
      int lat;
      logic [15:0] tt; logic [4:0] ec; logic ps;
      f_sel = 2'd0; expected = 16'h5362;
      model(f_sel, rnd_tt, expected, tt, ec, ps);
      do_sweep(1'b0, lat);
      n_cmp++;
      if (table1 !== tt) begin n_bad++; $display("FAIL one_err_table: got %h want %h", table1, tt); end
      n_cmp++;
      if (err1 !== ec) begin n_bad++; $display("FAIL one_err_count: got %0d want %0d", err1, ec); end
      n_cmp++;
      if (pass1 !== ps) begin n_bad++; $display("FAIL one_err_pass: got %b want %b", pass1, ps); end
   endtask

   task automatic test_all_errors;
      int lat;
      logic [15:0] tt; logic [4:0] ec; logic ps;
      f_sel = 2'd1; expected = 16'hFFFF;
      model(f_sel, rnd_tt, expected, tt, ec, ps);
      do_sweep(1'b0, lat);
      n_cmp++;
      if (table1 !== tt) begin n_bad++; $display("FAIL all_err_table: got %h want %h", table1, tt); end
      n_cmp++;
      if (err1 !== ec) begin n_bad++; $display("FAIL all_err_count: got %0d want %0d", err1, ec); end
      n_cmp++;
      if (pass1 !== ps) begin n_bad++; $display("FAIL all_err_pass: got %b want %b", pass1, ps); end
   endtask

   task automatic test_zero_expected;
      int lat;
      logic [15:0] tt; logic [4:0] ec; logic ps;
      f_sel = 2'd0; expected = 16'h0000;
      model(f_sel, rnd_tt, expected, tt, ec, ps);
      do_sweep(1'b0, lat);
      n_cmp++;
      if (table1 !== tt) begin n_bad++; $display("FAIL zero_exp_table: got %h want %h", table1, tt); end
      n_cmp++;
      if (err1 !== ec) begin n_bad++; $display("FAIL zero_exp_err: got %0d want %0d", err1, ec); end
      n_cmp++;
      if (pass1 !== ps) begin n_bad++; $display("FAIL zero_exp_pass: got %b want %b", pass1, ps); end
   endtask

   task automatic test_settle3;
      int k;
      logic [15:0] tt; logic [4:0] ec; logic ps;
      f_sel = 2'd0; expected = 16'h5363;
      model(f_sel, rnd_tt, expected, tt, ec, ps);
      @(posedge clk); #1;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      k = 0;
      // Each minterm spans SETTLE drive cycles plus one capture cycle.
      while (busy3 && k < 200) begin
         n_cmp++;
         if (abcd3 !== 4'(k / 4)) begin
            n_bad++; $display("FAIL settle3_abcd[%0d]: got %h want %h", k, abcd3, 4'(k / 4));
         end
         k++;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (k !== 64) begin n_bad++; $display("FAIL settle3_busy_len: got %0d want 64", k); end
      n_cmp++;
      if (done3 !== 1'b1) begin
         n_bad++; $display("FAIL settle3_latency: done=%b after %0d edges want 1 after 65", done3, k + 1);
      end
      n_cmp++;
      if ({table3, err3, pass3} !== {tt, ec, ps}) begin
         n_bad++; $display("FAIL settle3_result: got %h want %h", {table3, err3, pass3}, {tt, ec, ps});
      end
   endtask

   task automatic test_start_ignored;
      int lat;
      bit pulsed;
      logic [15:0] tt; logic [4:0] ec; logic ps;
      f_sel = 2'd0; expected = 16'h5363;
      model(f_sel, rnd_tt, expected, tt, ec, ps);
      @(posedge clk); #1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 1;
      pulsed = 1'b0;
      while (!done1 && lat < 200) begin
         if (!pulsed && busy1 && abcd1 == 4'd7) begin
            start1 = 1'b1;
            pulsed = 1'b1;
         end else begin
            start1 = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start1 = 1'b0;
      n_cmp++;
      if (lat !== 33) begin n_bad++; $display("FAIL restart_latency: got %0d want 33", lat); end
      n_cmp++;
      if ({table1, err1, pass1} !== {tt, ec, ps}) begin
         n_bad++; $display("FAIL restart_result: got %h want %h", {table1, err1, pass1}, {tt, ec, ps});
      end
      repeat (3) begin
         @(posedge clk); #1;
         n_cmp++;
         if (busy1 !== 1'b0) begin n_bad++; $display("FAIL restart_no_queue: busy got %b want 0", busy1); end
      end
   endtask

   task automatic test_reset_mid;
      int lat, n;
      logic [15:0] tt; logic [4:0] ec; logic ps;
      f_sel = 2'd0; expected = 16'h5363;
      model(f_sel, rnd_tt, expected, tt, ec, ps);
      @(posedge clk); #1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      n = 0;
      while (abcd1 != 4'd9 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      n_cmp++;
      if (abcd1 !== 4'd9) begin n_bad++; $display("FAIL rst_mid_reach9: got %h want 9", abcd1); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({abcd1, busy1, done1, table1, err1, pass1} !== 28'd0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: got %h want 0", {abcd1, busy1, done1, table1, err1, pass1});
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({abcd1, busy1, done1} !== 6'd0) begin
         n_bad++; $display("FAIL rst_mid_no_resume: got %h want 0", {abcd1, busy1, done1});
      end
      do_sweep(1'b0, lat);
      n_cmp++;
      if (lat !== 33) begin n_bad++; $display("FAIL rst_mid_resweep_latency: got %0d want 33", lat); end
      n_cmp++;
      if ({table1, err1, pass1} !== {tt, ec, ps}) begin
         n_bad++; $display("FAIL rst_mid_resweep_result: got %h want %h", {table1, err1, pass1}, {tt, ec, ps});
      end
   endtask

   task automatic test_random;
      int lat, exp_lat;
      bit use3;
      logic [15:0] tt; logic [4:0] ec; logic ps;
      f_sel = 2'd2;
      for (int it = 0; it < 8; it++) begin
         use3 = it[0];
         rnd_tt = 16'($urandom);
         case (it % 3)
            0:       expected = rnd_tt;
            1:       expected = rnd_tt ^ (16'h1 << $urandom_range(15, 0));
            default: expected = 16'($urandom);
         endcase
         model(f_sel, rnd_tt, expected, tt, ec, ps);
         exp_lat = use3 ? 65 : 33;
         do_sweep(use3, lat);
         n_cmp++;
         if (lat !== exp_lat) begin
            n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, exp_lat);
         end
         n_cmp++;
         if ((use3 ? table3 : table1) !== tt) begin
            n_bad++; $display("FAIL rand%0d_table: got %h want %h", it, use3 ? table3 : table1, tt);
         end
         n_cmp++;
         if ((use3 ? err3 : err1) !== ec) begin
            n_bad++; $display("FAIL rand%0d_err: got %0d want %0d", it, use3 ? err3 : err1, ec);
         end
         n_cmp++;
         if ((use3 ? pass3 : pass1) !== ps) begin
            n_bad++; $display("FAIL rand%0d_pass: got %b want %b", it, use3 ? pass3 : pass1, ps);
         end
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_one_error();
      test_all_errors();
      test_zero_expected();
      test_settle3();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
